// File: rtl/data_memory_responder.sv
// Load/store responder for the core's data port: one request at a time, a programmable
// wait, then a byte/half/word access into word storage with a registered ready/err pulse.
module data_memory_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  input  logic [2:0]  funct3,
  output logic [31:0] read_data,
  output logic        ready,
  output logic        err,
  output logic        busy
);

  localparam int         AW       = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state;
  logic [3:0]    cnt;

  logic          cap_rd;
  logic          cap_wr;
  logic [31:0]   cap_addr;
  logic [31:0]   cap_wd;
  logic [2:0]    cap_f3;

  logic [31:0]   mem [DEPTH_WORDS];

  logic [AW-1:0] widx;
  logic [1:0]    lane;
  logic [31:0]   cur_word;
  logic          acc_err;
  logic          commit;

  function automatic logic out_of_range(input logic [31:0] a);
    return {2'b00, a[31:2]} >= 32'(DEPTH_WORDS);
  endfunction

  // Unsigned-variant codes are loads only; a store carrying them is rejected.
  function automatic logic access_err(input logic rd, input logic wr,
                                      input logic [2:0] f3, input logic [31:0] a);
    logic bad_f3;
    logic misaligned;
    case (f3)
      F3_B, F3_H, F3_W: bad_f3 = 1'b0;
      F3_BU, F3_HU:     bad_f3 = wr;
      default:          bad_f3 = 1'b1;
    endcase
    misaligned = ((f3[1:0] == 2'b01) && a[0]) || ((f3 == F3_W) && (a[1:0] != 2'b00));
    return (rd && wr) || bad_f3 || misaligned || out_of_range(a);
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [2:0] f3, input logic [1:0] ln);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] bs;
    logic signed [31:0] hs;
    b  = word[{ln, 3'b000} +: 8];
    h  = word[{ln[1], 4'b0000} +: 16];
    bs = b;
    hs = h;
    case (f3)
      F3_B:    return bs;
      F3_BU:   return {24'b0, b};
      F3_H:    return hs;
      F3_HU:   return {16'b0, h};
      default: return word;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] wd,
                                              input logic [2:0] f3, input logic [1:0] ln);
    logic [31:0] r;
    r = old;
    case (f3[1:0])
      2'b00:   r[{ln, 3'b000} +: 8]     = wd[7:0];
      2'b01:   r[{ln[1], 4'b0000} +: 16] = wd[15:0];
      default: r = wd;
    endcase
    return r;
  endfunction

  assign widx     = cap_addr[AW+1:2];
  assign lane     = cap_addr[1:0];
  assign cur_word = mem[widx];
  assign acc_err  = access_err(cap_rd, cap_wr, cap_f3, cap_addr);
  assign commit   = (state == WAIT) && (cnt == 4'd0);

  // Request capture: only IDLE samples the port, so later input changes are ignored.
  always_ff @(posedge clk) begin
    if (state == IDLE && (mem_read || mem_write)) begin
      cap_rd   <= mem_read;
      cap_wr   <= mem_write;
      cap_addr <= addr;
      cap_wd   <= write_data;
      cap_f3   <= funct3;
    end
  end

  // Storage commit: shares the edge that raises ready, and reset suppresses it.
  always_ff @(posedge clk) begin
    if (!reset && commit && cap_wr && !acc_err) begin
      mem[widx] <= store_merge(cur_word, cap_wd, cap_f3, lane);
    end
  end

  // Control FSM and registered response.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      ready     <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
      read_data <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_read || mem_write) begin
            cnt   <= CNT_INIT;
            busy  <= 1'b1;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            ready <= 1'b1;
            state <= RESP;
            if (acc_err) begin
              err       <= 1'b1;
              read_data <= 32'd0;
            end else if (cap_wr) begin
              err       <= 1'b0;
              read_data <= 32'd0;
            end else begin
              err       <= 1'b0;
              read_data <= load_extract(cur_word, cap_f3, lane);
            end
          end
        end
        RESP: begin
          ready <= 1'b0;
          err   <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          ready <= 1'b0;
          err   <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/data_memory_responder.md
# data_memory_responder

Multi-cycle data-memory responder on the CPU's load/store port. It accepts one request at a time from the core's `Memread`/`Memwrite` control outputs, stalls for a programmable number of wait cycles, and performs a byte, half or word access into word-organised storage. It then returns sign- or zero-extended load data with a one-cycle `ready` pulse. It sits between the core's ALU-result/ReadData2 datapath and the write-back mux.

## Interface
- `DEPTH_WORDS`, 256: storage depth in 32-bit words; power of two.
- `LATENCY`, 2: wait cycles between request capture and access; legal range 1..15.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `mem_read` input 1: load request (core `Memread`).
- `mem_write` input 1: store request (core `Memwrite`).
- `addr` input 32: byte address (ALU result).
- `write_data` input 32: store data (ReadData2); low bytes are used for `sb`/`sh`.
- `funct3` input 3: access size and sign. Values: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- `read_data` output 32: load result.
- `ready` output 1: one-cycle response pulse.
- `err` output 1: qualifies `ready`; the request failed and had no side effect.
- `busy` output 1: high while a request is in flight.

## Operation
- Registered FSM with three states: IDLE, WAIT, RESP. Wait counter is 4 bits.
- IDLE: when `mem_read | mem_write` is high at an edge, capture `addr`, `write_data`, `funct3` and the request type. Set cnt <= LATENCY-1 and go to WAIT.
- WAIT:
  - If cnt != 0 at an edge: cnt <= cnt-1.
  - If cnt == 0 at an edge: perform the access, update `read_data`/`err`, set `ready` <= 1, go to RESP.
- RESP: `ready` is high for this one cycle only. Next edge returns to IDLE and clears `ready`/`err`.
- Request inputs are sampled only in IDLE. Changes in WAIT/RESP are ignored because captured copies are used.
- If a request is still asserted in the IDLE cycle after RESP, it is treated as a new request. The requester must drop the request in the cycle `ready` is seen.
- Word index is `addr[log2(DEPTH_WORDS)+1:2]`. Byte lane is `addr[1:0]`.
- Loads:
  - b: byte lane, sign-extended.
  - bu: byte lane, zero-extended.
  - h/hu: half at `addr[1]`, sign- or zero-extended.
  - w: full word.
- Stores: only the addressed lane(s) are written (byte enables). Other bytes of the word are preserved.
- Error conditions (`err`=1, no storage write, `read_data`=0):
  - `mem_read` and `mem_write` both high at capture.
  - `funct3` not in the legal set. Stores are further restricted to 000/001/010.
  - Half access with `addr[0]`=1.
  - Word access with `addr[1:0]`!=0.
  - `addr[31:2]` >= DEPTH_WORDS.
- Successful store: `read_data` <= 0, `err` <= 0.
- `read_data` holds its value until the next response.
- `busy` = (state != IDLE).

## Timing
- Reset values: state IDLE, cnt 0, `ready` 0, `err` 0, `read_data` 0, `busy` 0. Storage contents are not cleared by reset.
- Latency: a request first sampled at edge E gives `ready` high during the cycle after edge E+LATENCY. That is LATENCY+1 cycles from capture.
- Throughput: one request per LATENCY+2 cycles.
- The store commits on the same edge that raises `ready`. A load in a later request observes it.
- Reset has priority at every edge. If `reset` is high on the commit edge, no write occurs and `ready` stays 0.
- Reset during WAIT/RESP abandons the request. The FSM is in IDLE the following cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset then idle: `reset`=1 for 2 cycles, then release. Required: `ready`/`err`/`busy`/`read_data` all 0, and no `ready` without a request.
- Word round trip, LATENCY=2: sw 0xDEADBEEF @0x10, then lw @0x10. Required: each `ready` arrives exactly 3 cycles after capture, and the lw returns 0xDEADBEEF with `err`=0.
- Sub-word store and extension: sw 0x00000000 @0x20, sb 0x80 @0x21, sh 0xF00F @0x22. Then lw @0x20 returns 0xF00F8000; lb @0x21 returns 0xFFFFFF80; lbu @0x21 returns 0x00000080; lh @0x22 returns 0xFFFFF00F; lhu @0x22 returns 0x0000F00F.
- Errors:
  - lw @0x13 → `err`=1, `read_data`=0.
  - sh @0x31 → `err`=1 and the word at 0x30 is unchanged.
  - Read+write both high → `err`=1.
  - funct3=011 → `err`=1.
  - lw @4*DEPTH_WORDS → `err`=1.
- Reset mid-operation: sw 0x12345678 @0x40 over stale 0xAAAAAAAA. Assert `reset` on the commit edge. Required: no `ready`, and a subsequent lw @0x40 returns 0xAAAAAAAA.
- Held request and input changes: keep `mem_read` high across `ready`. Required: a second response follows with `busy` dropping for exactly one IDLE cycle. Changing `addr` during WAIT does not alter the result.
